// File: rtl/reg_file_if.sv
// Dispatch/commit bundle between the reorder buffer, dispatch stage and register file.
// No handshakes: every pulse (commit, dispatch, roll) is consumed in the cycle it is high.
interface reg_file_if #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
);
  logic             rdy;
  logic             ROB_roll;
  logic             RF_write_flag;
  logic [4:0]       RF_rd;
  logic [ROB_W-1:0] RF_ROB_idx;
  logic [XLEN-1:0]  RF_val;
  logic             Dis_flag;
  logic [4:0]       Dis_rd;
  logic [ROB_W-1:0] Dis_ROB_idx;
  logic [4:0]       Dis_rs1;
  logic [4:0]       Dis_rs2;
  logic             Dis_busy1;
  logic             Dis_busy2;
  logic [ROB_W-1:0] Dis_tag1;
  logic [ROB_W-1:0] Dis_tag2;
  logic [XLEN-1:0]  Dis_val1;
  logic [XLEN-1:0]  Dis_val2;

  modport master (
    output rdy, ROB_roll, RF_write_flag, RF_rd, RF_ROB_idx, RF_val,
           Dis_flag, Dis_rd, Dis_ROB_idx, Dis_rs1, Dis_rs2,
    input  Dis_busy1, Dis_busy2, Dis_tag1, Dis_tag2, Dis_val1, Dis_val2
  );

  modport slave (
    input  rdy, ROB_roll, RF_write_flag, RF_rd, RF_ROB_idx, RF_val,
           Dis_flag, Dis_rd, Dis_ROB_idx, Dis_rs1, Dis_rs2,
    output Dis_busy1, Dis_busy2, Dis_tag1, Dis_tag2, Dis_val1, Dis_val2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file plus rename table: per-register value, busy bit and producer tag,
// with two combinational operand queries that bypass a same-cycle matching commit.
module reg_file #(
  parameter int REG_NUM = 32,
  parameter int ROB_W   = 4,
  parameter int XLEN    = 32
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic [XLEN-1:0]    regs_q [REG_NUM];
  logic [XLEN-1:0]    regs_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [ROB_W-1:0]   tag_q  [REG_NUM];
  logic [ROB_W-1:0]   tag_d  [REG_NUM];

  logic commit_en;
  logic rename_en;

  assign commit_en = bus.RF_write_flag && (bus.RF_rd != 5'd0);
  assign rename_en = bus.Dis_flag && (bus.Dis_rd != 5'd0);

  // Roll beats rename, rename beats the commit's busy clear; the commit value always lands.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.rdy) begin
      if (commit_en) begin
        regs_d[bus.RF_rd] = bus.RF_val;
        if (busy_q[bus.RF_rd] && (tag_q[bus.RF_rd] == bus.RF_ROB_idx)) begin
          busy_d[bus.RF_rd] = 1'b0;
        end
      end
      if (bus.ROB_roll) begin
        busy_d = '0;
      end else if (rename_en) begin
        busy_d[bus.Dis_rd] = 1'b1;
        tag_d[bus.Dis_rd]  = bus.Dis_ROB_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  logic [4:0] q_rs [2];
  assign q_rs[0] = bus.Dis_rs1;
  assign q_rs[1] = bus.Dis_rs2;

  // Queries see pre-edge state, so an instruction renaming its own source reads the older producer.
  for (genvar p = 0; p < 2; p++) begin : g_q
    logic             busy_c;
    logic [ROB_W-1:0] tag_c;
    logic [XLEN-1:0]  val_c;
    always_comb begin
      busy_c = 1'b0;
      tag_c  = '0;
      val_c  = '0;
      if (q_rs[p] == 5'd0) begin
        busy_c = 1'b0;
      end else if (busy_q[q_rs[p]]) begin
        if (bus.RF_write_flag && (bus.RF_rd == q_rs[p]) &&
            (tag_q[q_rs[p]] == bus.RF_ROB_idx)) begin
          val_c = bus.RF_val;
        end else begin
          busy_c = 1'b1;
          tag_c  = tag_q[q_rs[p]];
        end
      end else begin
        val_c = regs_q[q_rs[p]];
      end
    end
  end

  assign bus.Dis_busy1 = g_q[0].busy_c;
  assign bus.Dis_tag1  = g_q[0].tag_c;
  assign bus.Dis_val1  = g_q[0].val_c;
  assign bus.Dis_busy2 = g_q[1].busy_c;
  assign bus.Dis_tag2  = g_q[1].tag_c;
  assign bus.Dis_val2  = g_q[1].val_c;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: each query pushes {busy,tag,val} expectations and pops them on sampling.
module tb_reg_file;
  localparam int ROB_W = 4;
  localparam int XLEN  = 32;
  localparam int W     = 1 + ROB_W + XLEN;

  logic clk;
  logic rst;

  reg_file_if #(.ROB_W(ROB_W), .XLEN(XLEN)) bus ();

  reg_file #(.REG_NUM(32), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q [$];
  int n_vec;
  int n_err;

  function automatic logic [W-1:0] ex(input logic b, input logic [ROB_W-1:0] t,
                                      input logic [XLEN-1:0] v);
    return {b, t, v};
  endfunction

  // Advance to the next falling edge (passing one rising edge) and clear all pulses.
  task automatic cyc();
    @(negedge clk);
    bus.rdy           = 1'b1;
    bus.ROB_roll      = 1'b0;
    bus.RF_write_flag = 1'b0;
    bus.RF_rd         = 5'd0;
    bus.RF_ROB_idx    = '0;
    bus.RF_val        = '0;
    bus.Dis_flag      = 1'b0;
    bus.Dis_rd        = 5'd0;
    bus.Dis_ROB_idx   = '0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [ROB_W-1:0] idx,
                        input logic [XLEN-1:0] v);
    bus.RF_write_flag = 1'b1;
    bus.RF_rd         = rd;
    bus.RF_ROB_idx    = idx;
    bus.RF_val        = v;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [ROB_W-1:0] idx);
    bus.Dis_flag    = 1'b1;
    bus.Dis_rd      = rd;
    bus.Dis_ROB_idx = idx;
  endtask

  task automatic query(input string nm, input logic [4:0] a, input logic [W-1:0] ea,
                       input logic [4:0] b, input logic [W-1:0] eb);
    logic [W-1:0] e;
    logic [W-1:0] o;
    bus.Dis_rs1 = a;
    bus.Dis_rs2 = b;
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    #2;
    e = exp_q.pop_front();
    o = {bus.Dis_busy1, bus.Dis_tag1, bus.Dis_val1};
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s rs1=x%0d: got %h expected %h", nm, a, o, e);
    end
    e = exp_q.pop_front();
    o = {bus.Dis_busy2, bus.Dis_tag2, bus.Dis_val2};
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s rs2=x%0d: got %h expected %h", nm, b, o, e);
    end
  endtask

  logic [W-1:0] z;

  initial begin
    n_vec = 0;
    n_err = 0;
    z = ex(1'b0, '0, '0);
    bus.Dis_rs1 = 5'd0;
    bus.Dis_rs2 = 5'd0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state and x0 hard-wiring
    query("reset", 5'd5, z, 5'd0, z);
    commit(5'd0, 4'd0, 32'hDEAD);
    query("x0_commit_same", 5'd0, z, 5'd0, z);
    cyc();
    query("x0_commit_after", 5'd0, z, 5'd5, z);

    // Rename then matching commit with bypass
    rename(5'd3, 4'd7);
    query("rename_same_cycle", 5'd3, z, 5'd0, z);
    cyc();
    query("rename_visible", 5'd3, ex(1'b1, 4'd7, '0), 5'd0, z);
    commit(5'd3, 4'd7, 32'h1234);
    query("commit_bypass", 5'd3, ex(1'b0, '0, 32'h1234), 5'd0, z);
    cyc();
    query("commit_regs", 5'd0, z, 5'd3, ex(1'b0, '0, 32'h1234));

    // Stale commit must not clear a younger producer
    rename(5'd4, 4'd2);
    cyc();
    rename(5'd4, 4'd5);
    query("x4_tag2", 5'd4, ex(1'b1, 4'd2, '0), 5'd0, z);
    cyc();
    commit(5'd4, 4'd2, 32'hAA);
    query("x4_stale_same", 5'd4, ex(1'b1, 4'd5, '0), 5'd3, ex(1'b0, '0, 32'h1234));
    cyc();
    query("x4_stale_after", 5'd4, ex(1'b1, 4'd5, '0), 5'd0, z);
    commit(5'd4, 4'd5, 32'hBB);
    query("x4_match_same", 5'd0, z, 5'd4, ex(1'b0, '0, 32'hBB));
    cyc();
    query("x4_match_after", 5'd4, ex(1'b0, '0, 32'hBB), 5'd0, z);

    // Commit and rename to the same register in one cycle
    rename(5'd6, 4'd1);
    cyc();
    commit(5'd6, 4'd1, 32'h66);
    rename(5'd6, 4'd9);
    query("x6_both_same", 5'd6, ex(1'b0, '0, 32'h66), 5'd0, z);
    cyc();
    query("x6_both_after", 5'd6, ex(1'b1, 4'd9, '0), 5'd0, z);

    // Rename x1..x8, then roll with a matching commit and an ignored dispatch
    for (int i = 1; i <= 8; i++) begin
      rename(5'(i), 4'(i));
      cyc();
    end
    query("renamed_1_8", 5'd1, ex(1'b1, 4'd1, '0), 5'd8, ex(1'b1, 4'd8, '0));
    bus.ROB_roll = 1'b1;
    commit(5'd1, 4'd1, 32'h42);
    rename(5'd2, 4'd15);
    query("roll_same", 5'd1, ex(1'b0, '0, 32'h42), 5'd2, ex(1'b1, 4'd2, '0));
    cyc();
    query("roll_x1_x2", 5'd1, ex(1'b0, '0, 32'h42), 5'd2, z);
    query("roll_x3_x4", 5'd3, ex(1'b0, '0, 32'h1234), 5'd4, ex(1'b0, '0, 32'hBB));
    query("roll_x6_x8", 5'd6, ex(1'b0, '0, 32'h66), 5'd8, z);

    // rdy low freezes all state
    bus.rdy = 1'b0;
    commit(5'd5, 4'd0, 32'h55);
    rename(5'd7, 4'd3);
    query("hold_same", 5'd5, z, 5'd7, z);
    cyc();
    query("hold_after", 5'd5, z, 5'd7, z);
    commit(5'd5, 4'd0, 32'h55);
    rename(5'd7, 4'd3);
    cyc();
    query("rdy_resume", 5'd5, ex(1'b0, '0, 32'h55), 5'd7, ex(1'b1, 4'd3, '0));

    // Random commits to untouched registers, with an opposite-port x0 check
    for (int k = 0; k < 8; k++) begin
      logic [4:0]      r;
      logic [XLEN-1:0] v;
      r = 5'($urandom_range(9, 31));
      v = $urandom;
      commit(r, 4'($urandom_range(0, 15)), v);
      cyc();
      query("rand_commit", 5'd0, z, r, ex(1'b0, '0, v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with a rename (register-status) table for the Tomasulo core. It receives in-order commit writes from the reorder buffer and records the newest in-flight producer tag per register on every dispatch. It answers two combinational operand queries per cycle for dispatch and drops all rename state on a reorder-buffer roll.

## Interface
- `REG_NUM`, 32, number of architectural registers; x0 is hard-wired to zero.
- `ROB_W`, 4, width of a reorder-buffer index.
- `XLEN`, 32, data width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `rdy`  in  1  global enable; state holds while low.
- `ROB_roll`  in  1  misprediction flush.
- `RF_write_flag`  in  1  commit write valid.
- `RF_rd`  in  5  commit destination register.
- `RF_ROB_idx`  in  ROB_W  reorder-buffer slot being committed.
- `RF_val`  in  XLEN  committed value.
- `Dis_flag`  in  1  dispatch valid; renames `Dis_rd`.
- `Dis_rd`  in  5  dispatch destination register.
- `Dis_ROB_idx`  in  ROB_W  slot allocated to the dispatched instruction.
- `Dis_rs1`, `Dis_rs2`  in  5  source register queries.
- `Dis_busy1`, `Dis_busy2`  out  1  operand pending in the reorder buffer.
- `Dis_tag1`, `Dis_tag2`  out  ROB_W  producer slot when busy; 0 otherwise.
- `Dis_val1`, `Dis_val2`  out  XLEN  operand value when not busy; 0 otherwise.

## Operation
- State per register: `regs` (XLEN), `busy` (1), `tag` (ROB_W).
- Reset: all `regs`, `busy` and `tag` are cleared to 0. Outputs are combinational from state, so after reset every query returns busy=0, tag=0, val=0.
- Commit (`RF_write_flag` and `RF_rd`≠0):
  - `regs[RF_rd]` <= `RF_val`.
  - If `busy[RF_rd]` and `tag[RF_rd]`==`RF_ROB_idx`, clear `busy[RF_rd]`.
  - A tag mismatch means a younger writer exists; busy and tag stay unchanged.
- Rename (`Dis_flag` and `Dis_rd`≠0 and not `ROB_roll`): `busy[Dis_rd]` <= 1 and `tag[Dis_rd]` <= `Dis_ROB_idx`.
- Commit and rename to the same register in the same cycle:
  - The value is written.
  - The rename wins for busy and tag, so the result is busy=1 with the new tag.
- Roll (`ROB_roll`=1):
  - Every `busy` bit is cleared.
  - Dispatch is ignored.
  - A commit in the same cycle is still applied to `regs`. This case occurs because the ROB raises the roll together with a JALR commit.
- Writes or renames to x0 are discarded. `regs[0]` stays 0 and `busy[0]` stays 0.
- Query path for each of rs1 and rs2 (evaluated independently, combinational):
  - rs==0: busy=0, tag=0, val=0.
  - busy[rs], with `RF_write_flag`, `RF_rd`==rs and `tag[rs]`==`RF_ROB_idx` (same-cycle commit bypass): busy=0, tag=0, val=`RF_val`.
  - busy[rs] in any other case: busy=1, tag=`tag[rs]`, val=0.
  - Otherwise: busy=0, tag=0, val=`regs[rs]`.
- A query returns the state before the same-cycle rename. For `addi x1,x1,1`, rs1 sees the previous producer of x1, not its own slot.
- `rdy`=0: no state changes (commit, rename and roll are all ignored). The query outputs remain valid.

## Timing
- Updates take effect at the rising edge.
- A committed value is visible to queries combinationally in the commit cycle through the bypass, and from `regs` in every cycle after.
- A rename is visible to queries in the cycle after `Dis_flag`.
- After a roll, all registers read not-busy from the next cycle onward.
- No handshakes: every input pulse is consumed in its cycle.
- Precedence per register per edge: rst > !rdy hold > roll (clears busy, keeps the commit) > rename > commit-clear.

## Test plan
- Reset, then query x5 and x0 → busy=0, val=0 for both. Commit x0←0xDEAD → x0 still reads 0.
- Rename x3 to tag 7; next cycle query x3 → busy=1, tag=7. Commit x3=0x1234 with tag 7 → the same-cycle query gives busy=0, val=0x1234. The next cycle reads the same from `regs`.
- Rename x4 to tag 2, then to tag 5. Commit x4=0xAA with tag 2 → x4 stays busy with tag 5 and `regs[4]`=0xAA. Commit with tag 5 → not busy.
- Same cycle: commit x6 with tag 1 (busy, tag 1) and rename x6 to tag 9 → next cycle busy=1, tag=9, and `regs[6]` holds the committed value.
- Rename x1..x8, then pulse `ROB_roll` together with a commit x1=0x42 (tag match) → all registers not busy and x1 reads 0x42. A `Dis_flag` in that cycle has no effect.
- Hold `rdy`=0 while driving a commit and a rename → no change. Raise `rdy` → the next pulse applies normally.
